// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;
    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned WAIT_CNT_WIDTH = 4;
    localparam logic [WORD_WIDTH-1:0] RV32_NOP = 32'h0000_0013;

    // Responder FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_READ = 2'd2;
    localparam state_t ST_RESP = 2'd3;
endpackage

// File: rtl/imem_responder_if.sv
// Cache refill request bus: single word, valid held until ready.
interface imem_responder_if;
    import imem_pkg::*;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [WORD_WIDTH-1:0] mem_req_addr;
    logic [WORD_WIDTH-1:0] mem_req_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_req_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_req_rdata
    );
endinterface

// File: rtl/imem_wait_counter.sv
// Loadable down-counter with zero/one detect; saturates at zero.
module imem_wait_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign one_o  = (count_q == WIDTH'(1));
endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for icache refills: wait states, one-cycle SRAM read,
// one-cycle ready pulse, out-of-range NOP substitution and a response counter.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 14,
    parameter int unsigned           WAIT_STATES = 2,
    parameter logic [WORD_WIDTH-1:0] OOR_DATA    = RV32_NOP
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_responder_if.slave       bus,
    output logic                  sram_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [WORD_WIDTH-1:0] sram_rdata,
    output logic                  err_oor,
    input  logic                  err_clr,
    output logic [WORD_WIDTH-1:0] req_count
);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  oor_q, oor_d;
    logic                  err_q, err_d;
    logic [WORD_WIDTH-1:0] count_q, count_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic [WORD_WIDTH-1:0] resp_word;
    logic                  req_oor;
    logic                  cnt_load, cnt_dec, cnt_zero, cnt_one;
    logic                  unused_addr_lsb;

    // Any address bit above the SRAM word range marks the request out of range.
    assign req_oor         = (bus.mem_req_addr >> (ADDR_WIDTH + 2)) != '0;
    assign unused_addr_lsb = ^bus.mem_req_addr[1:0];
    assign resp_word       = oor_q ? OOR_DATA : sram_rdata;

    imem_wait_counter #(
        .WIDTH (WAIT_CNT_WIDTH)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (WAIT_CNT_WIDTH'(WAIT_STATES)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    // Next-state and datapath updates; a dropped valid in WAIT/READ aborts.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        oor_d    = oor_q;
        err_d    = err_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_req_valid) begin
                    addr_d   = bus.mem_req_addr[ADDR_WIDTH+1:2];
                    oor_d    = req_oor;
                    cnt_load = 1'b1;
                    state_d  = (WAIT_STATES == 0) ? ST_READ : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.mem_req_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_one || cnt_zero) begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (!bus.mem_req_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                    count_d = count_q + WORD_WIDTH'(1);
                    if (oor_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                rdata_d = resp_word;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM data only arrives during RESP, so that cycle bypasses the hold register.
    assign bus.mem_req_ready = (state_q == ST_RESP);
    assign bus.mem_req_rdata = (state_q == ST_RESP) ? resp_word : rdata_q;
    assign sram_en           = (state_q == ST_READ) && !oor_q;
    assign sram_addr         = (state_q == ST_READ) ? addr_q : '0;
    assign err_oor           = err_q;
    assign req_count         = count_q;
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the instruction cache refill interface (mem_req_valid/ready/addr/rdata), single-word, valid-held-until-ready protocol.
- Accepts one word read at a time and inserts a configurable number of wait states, modelling slow instruction memory.
- Fetches the word from a synchronous single-port SRAM (one-cycle read latency) and returns it with a one-cycle ready pulse.
- Sits between icache_direct_mapped and the instruction SRAM macro; replaces the behavioural memory model in synthesizable builds.

Parameters:
- ADDR_WIDTH, 14, SRAM word-address width (memory depth = 2**ADDR_WIDTH words).
- WAIT_STATES, 2, extra idle cycles between request accept and SRAM read (0..15 legal).
- OOR_DATA, 32'h0000_0013, word returned for out-of-range addresses (RV32 NOP).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req_valid  in  1  request from cache; held high until mem_req_ready is seen.
- mem_req_ready  out  1  one-cycle pulse; mem_req_rdata is valid in that cycle.
- mem_req_addr  in  32  byte address; bits [1:0] ignored.
- mem_req_rdata  out  32  returned instruction word.
- sram_en  out  1  SRAM read enable.
- sram_addr  out  ADDR_WIDTH  SRAM word address = mem_req_addr[ADDR_WIDTH+1:2].
- sram_rdata  in  32  SRAM data, valid the cycle after sram_en.
- err_oor  out  1  sticky flag; set when an out-of-range address is accepted.
- err_clr  in  1  synchronous clear of err_oor.
- req_count  out  32  number of completed responses, wraps at 2**32.

Behaviour:
- Reset (async assert, sync-released by the environment): state=IDLE, mem_req_ready=0, mem_req_rdata=0, sram_en=0, sram_addr=0, err_oor=0, req_count=0, wait counter=0.
- FSM states: IDLE, WAIT, READ, RESP.
- IDLE: if mem_req_valid=1, latch address to addr_q. Set oor_q = |mem_req_addr[31:ADDR_WIDTH+2]. Load wait counter with WAIT_STATES. Go to WAIT, or to READ if WAIT_STATES=0.
- WAIT: decrement counter. When the counter reaches 1, go to READ next cycle, so WAIT lasts exactly WAIT_STATES cycles.
- READ: sram_en=1 and sram_addr=addr_q, both combinational from state, for exactly one cycle. If oor_q=1, sram_en stays 0. Go to RESP.
- RESP: mem_req_ready=1 for exactly one cycle. mem_req_rdata = oor_q ? OOR_DATA : sram_rdata, registered into rdata_q and driven from it. On entry, req_count increments. If oor_q=1, err_oor sets. Go to IDLE.
- Latency: valid first high in cycle N gives ready high in cycle N+WAIT_STATES+2. WAIT_STATES=2 gives ready at N+4.
- Back-to-back requests: the cache drops or changes valid on the edge where it samples ready. IDLE therefore samples fresh valid the cycle after RESP, so minimum request spacing is WAIT_STATES+3 cycles.
- Abort: if mem_req_valid falls while in WAIT or READ, go to IDLE next cycle. No ready pulse, req_count unchanged, err_oor unchanged. The SRAM read already issued is discarded.
- mem_req_addr changing while valid is high and a request is in flight is a protocol violation. The latched addr_q is used.
- mem_req_rdata holds its last value outside RESP.
- err_clr and a new OOR set in the same cycle: the set wins.
- req_count wraps from 32'hFFFF_FFFF to 0 without side effects.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. No ready pulse is emitted.

Decomposition:
- Shared package imem_pkg: FSM state enum (IDLE, WAIT, READ, RESP), WORD_WIDTH=32, RV32_NOP=32'h0000_0013.
- One natural sub-module: imem_wait_counter, a loadable down-counter with zero/one detect.
- The FSM and datapath stay flat in imem_responder.

Test Plan:
- Reset then single read, WAIT_STATES=2: SRAM[0]=32'hDEAD_BEEF; valid=1, addr=0 at cycle N. Expect sram_en=1 with sram_addr=0 at N+3; ready=1 with rdata=DEADBEEF at N+4 only; req_count=1.
- WAIT_STATES=0: addr=32'h0000_0004, SRAM[1]=32'h1234_5678. Expect ready at N+2 with rdata=12345678.
- Out-of-range: addr=32'h0001_0000 with ADDR_WIDTH=14. Expect sram_en never high, rdata=32'h0000_0013 at N+4, and err_oor=1. Pulse err_clr, then expect err_oor=0.
- Abort: valid high at N, low at N+2. Expect no ready pulse, req_count unchanged, FSM in IDLE at N+3. A new request to addr 8 then completes normally.
- Back-to-back: three requests (0, 4, 0) each held until ready. Expect three single-cycle ready pulses spaced 5 cycles apart with correct words, and req_count=3.
- Async reset asserted during WAIT: expect ready=0, rdata=0, req_count=0 immediately, before the next clock edge.
